i2c_cmd_sequencer: RTL and testbench

//  Upstream command front-end for the i2c master. Queues register-access commands in a small FIFO,

---
 rtl/i2c_cmd_sequencer_if.sv | 34 +++
 rtl/i2c_cmd_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response bundle between an upstream requester and the i2c command
// sequencer.
//   cmd_*  : requester offers a register-access command (valid/ready).
//   rsp_*  : sequencer returns the outcome of the oldest command (valid/ready).
// Modports:
//   master : the requester side (drives commands, consumes responses).
//   slave  : the sequencer side (accepts commands, produces responses).
interface i2c_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_slave_addr;
  logic       cmd_rw;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_rw;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;

  modport master (
    output cmd_valid, cmd_slave_addr, cmd_rw, cmd_reg_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rw, rsp_rdata, rsp_timeout,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_slave_addr, cmd_rw, cmd_reg_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rw, rsp_rdata, rsp_timeout,
    input  rsp_ready
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Front-end for an i2c master: queues register-access commands, launches them
// one at a time with a single-cycle en_start pulse, detects completion by a
// run of quiet (high) scl cycles, and reports read data / timeout status.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : cmd_* command push, rsp_* response pop
//   busy            : a command is in flight or queued
//   fifo_level      : command FIFO occupancy
//   m_en_start      : one-cycle start pulse to the master
//   m_slave_addr, m_read_write, m_reg_addr, m_wdata : operands held for the master
//   m_scl, m_rdata  : master clock line and read data, observed for completion
module i2c_cmd_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int QUIET_CYCLES = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  i2c_cmd_sequencer_if.slave            bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          m_en_start,
  output logic [6:0]                    m_slave_addr,
  output logic                          m_read_write,
  output logic [7:0]                    m_reg_addr,
  output logic [7:0]                    m_wdata,
  input  logic                          m_scl,
  input  logic [7:0]                    m_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int QW    = $clog2(QUIET_CYCLES + 1);

  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY   = {LVL_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [QW-1:0]    QUIET_LIMIT = QW'(QUIET_CYCLES);
  localparam logic [QW-1:0]    QUIET_ZERO  = {QW{1'b0}};

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_ACT  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  typedef struct packed {
    logic [6:0] slave_addr;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } cmd_t;

  localparam cmd_t CMD_ZERO = cmd_t'(24'd0);

  cmd_t             fifo_mem_r [FIFO_DEPTH];
  cmd_t             cmd_in_s;
  cmd_t             op_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_next_s;
  logic             push_s;
  logic             pop_s;

  logic [2:0]       state_r;
  logic [2:0]       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [QW-1:0]    quiet_r;
  logic [QW-1:0]    quiet_next_s;
  logic [QW-1:0]    quiet_inc_s;
  logic             en_start_r;
  logic             en_start_next_s;

  logic             cmd_ready_r;
  logic             busy_r;
  logic             rsp_valid_r;
  logic             rsp_valid_next_s;
  logic             rsp_rw_r;
  logic             rsp_rw_next_s;
  logic [7:0]       rsp_rdata_r;
  logic [7:0]       rsp_rdata_next_s;
  logic             rsp_timeout_r;
  logic             rsp_timeout_next_s;

  assign cmd_in_s    = {bus.cmd_slave_addr, bus.cmd_rw, bus.cmd_reg_addr, bus.cmd_wdata};
  assign push_s      = bus.cmd_valid && cmd_ready_r;
  assign cnt_inc_s   = cnt_r + CNT_W'(1);
  assign quiet_inc_s = quiet_r + QW'(1);

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_W'(1);
      2'b01:   level_next_s = level_r - LVL_W'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Sequencer next-state, counters and response fields
  always_comb begin
    state_next_s       = state_r;
    cnt_next_s         = cnt_r;
    quiet_next_s       = quiet_r;
    en_start_next_s    = 1'b0;
    pop_s              = 1'b0;
    rsp_valid_next_s   = rsp_valid_r;
    rsp_rw_next_s      = rsp_rw_r;
    rsp_rdata_next_s   = rsp_rdata_r;
    rsp_timeout_next_s = rsp_timeout_r;
    case (state_r)
      IDLE: begin
        if ((level_r != LVL_EMPTY) && !rsp_valid_r) begin
          pop_s        = 1'b1;
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      // Operands settle for one cycle, then en_start pulses for one cycle.
      START: begin
        if (!en_start_r) begin
          en_start_next_s = 1'b1;
          state_next_s    = START;
        end else begin
          cnt_next_s   = CNT_ZERO;
          state_next_s = WAIT_ACT;
        end
      end
      WAIT_ACT: begin
        cnt_next_s = cnt_inc_s;
        if (cnt_inc_s == CNT_LIMIT) begin
          state_next_s       = RESP;
          rsp_valid_next_s   = 1'b1;
          rsp_rw_next_s      = op_r.rw;
          rsp_rdata_next_s   = 8'h00;
          rsp_timeout_next_s = 1'b1;
        end else if (!m_scl) begin
          quiet_next_s = QUIET_ZERO;
          state_next_s = WAIT_DONE;
        end else begin
          state_next_s = WAIT_ACT;
        end
      end
      // Short scl-high gaps (repeated start) never reach the quiet limit.
      WAIT_DONE: begin
        cnt_next_s = cnt_inc_s;
        if (m_scl) begin
          quiet_next_s = quiet_inc_s;
        end else begin
          quiet_next_s = QUIET_ZERO;
        end
        if (cnt_inc_s == CNT_LIMIT) begin
          state_next_s       = RESP;
          rsp_valid_next_s   = 1'b1;
          rsp_rw_next_s      = op_r.rw;
          rsp_rdata_next_s   = 8'h00;
          rsp_timeout_next_s = 1'b1;
        end else if (quiet_next_s == QUIET_LIMIT) begin
          state_next_s       = RESP;
          rsp_valid_next_s   = 1'b1;
          rsp_rw_next_s      = op_r.rw;
          rsp_rdata_next_s   = op_r.rw ? m_rdata : 8'h00;
          rsp_timeout_next_s = 1'b0;
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next_s = 1'b0;
          state_next_s     = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        rsp_valid_next_s = 1'b0;
        state_next_s     = IDLE;
      end
    endcase
  end

  // Command FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= CMD_ZERO;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= LVL_EMPTY;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= cmd_in_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_next_s;
    end
  end

  // FSM state, counters, operand holding and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      quiet_r       <= QUIET_ZERO;
      en_start_r    <= 1'b0;
      op_r          <= CMD_ZERO;
      cmd_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rw_r      <= 1'b0;
      rsp_rdata_r   <= 8'h00;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      quiet_r       <= quiet_next_s;
      en_start_r    <= en_start_next_s;
      if (pop_s) begin
        op_r <= fifo_mem_r[rd_ptr_r];
      end
      cmd_ready_r   <= (level_next_s != LVL_FULL);
      busy_r        <= (state_next_s != IDLE) || (level_next_s != LVL_EMPTY);
      rsp_valid_r   <= rsp_valid_next_s;
      rsp_rw_r      <= rsp_rw_next_s;
      rsp_rdata_r   <= rsp_rdata_next_s;
      rsp_timeout_r <= rsp_timeout_next_s;
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rw      = rsp_rw_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_timeout = rsp_timeout_r;
  assign busy            = busy_r;
  assign fifo_level      = level_r;
  assign m_en_start      = en_start_r;
  assign m_slave_addr    = op_r.slave_addr;
  assign m_read_write    = op_r.rw;
  assign m_reg_addr      = op_r.reg_addr;
  assign m_wdata         = op_r.wdata;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Testbench for i2c_cmd_sequencer. A small behavioural master answers each
// en_start with an scl burst (with a repeated-start gap for reads) and returns
// read data = reg_addr ^ 8'h1E. Table-driven command vectors plus hand-written
// sequences for FIFO fill, response stall, timeout and mid-transaction reset.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int QUIET = 4;
  localparam int TO    = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] fifo_level;
  logic       m_en_start;
  logic [6:0] m_slave_addr;
  logic       m_read_write;
  logic [7:0] m_reg_addr;
  logic [7:0] m_wdata;
  logic       m_scl;
  logic [7:0] m_rdata;

  i2c_cmd_sequencer_if bus_if ();

  i2c_cmd_sequencer #(
    .FIFO_DEPTH(DEPTH), .QUIET_CYCLES(QUIET), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .busy(busy), .fifo_level(fifo_level),
    .m_en_start(m_en_start), .m_slave_addr(m_slave_addr), .m_read_write(m_read_write),
    .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_scl(m_scl), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [6:0] sa;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [7:0] exp_rdata;
  } vec_t;

  int tests = 0;
  int failed = 0;
  int en_cnt = 0;
  int en_overlap = 0;
  int ready_err = 0;
  int max_level = 0;
  bit master_on = 1'b1;
  bit in_txn = 1'b0;
  bit ready_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: start-pulse count, cmd_ready vs level, peak level.
  always @(negedge clk) begin
    if (m_en_start) en_cnt++;
    if (bus_if.cmd_ready !== (fifo_level != 3'd4)) ready_err++;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  // Behavioural master: flags any en_start seen while a transaction runs.
  task automatic mcyc();
    @(negedge clk);
    if (m_en_start) en_overlap++;
  endtask

  task automatic mbit();
    m_scl = 1'b0; mcyc(); mcyc();
    m_scl = 1'b1; mcyc(); mcyc();
  endtask

  initial begin
    logic       cur_rw;
    logic [7:0] cur_reg;
    m_scl = 1'b1;
    m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (m_en_start && master_on) begin
        in_txn  = 1'b1;
        cur_rw  = m_read_write;
        cur_reg = m_reg_addr;
        mcyc(); mcyc();
        for (int b = 0; b < 27; b++) mbit();
        if (cur_rw) begin
          mcyc();  // third high cycle: repeated-start gap
          for (int b = 0; b < 18; b++) mbit();
        end
        m_rdata = cur_reg ^ 8'h1E;
        m_scl   = 1'b1;
        in_txn  = 1'b0;
      end
    end
  end

  task automatic push(input vec_t v);
    int k = 0;
    bus_if.cmd_valid      = 1'b1;
    bus_if.cmd_rw         = v.rw;
    bus_if.cmd_slave_addr = v.sa;
    bus_if.cmd_reg_addr   = v.ra;
    bus_if.cmd_wdata      = v.wd;
    while (!bus_if.cmd_ready && k < 2000) begin @(negedge clk); k++; end
    if (!bus_if.cmd_ready) begin
      tests++; failed++;
      $display("FAIL push: cmd_ready stuck low");
    end
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic start_latency(input string tag);
    int k = 0;
    while (!m_en_start && k < 10) begin @(negedge clk); k++; end
    check({tag, " en_start latency"}, 64'(k), 64'd2);
  endtask

  task automatic get_rsp(input string tag, input vec_t v, input logic exp_to);
    int k = 0;
    while (!bus_if.rsp_valid && k < 3000) begin @(negedge clk); k++; end
    check({tag, " rsp_valid"},   64'(bus_if.rsp_valid),   64'd1);
    check({tag, " rsp_rw"},      64'(bus_if.rsp_rw),      64'(v.rw));
    check({tag, " rsp_rdata"},   64'(bus_if.rsp_rdata),   64'(v.exp_rdata));
    check({tag, " rsp_timeout"}, 64'(bus_if.rsp_timeout), 64'(exp_to));
    check({tag, " m_slave_addr"}, 64'(m_slave_addr), 64'(v.sa));
    check({tag, " m_reg_addr"},   64'(m_reg_addr),   64'(v.ra));
    if (!v.rw) check({tag, " m_wdata"}, 64'(m_wdata), 64'(v.wd));
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = ready_hold;
  endtask

  function automatic logic [40:0] snap();
    return {bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_rw, bus_if.rsp_rdata,
            bus_if.rsp_timeout, busy, fifo_level, m_en_start, m_slave_addr,
            m_read_write, m_reg_addr, m_wdata};
  endfunction

  vec_t vecs [5];
  vec_t fvecs [5];
  vec_t svecs [2];
  vec_t tvec;
  vec_t rvec;
  vec_t pvec;

  initial begin
    logic [40:0] rst_exp;
    logic [9:0]  held;
    int          k;
    int          e0;
    int          stall_err;

    vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 7'h1A, 8'hFF, 8'h99, 8'hE1};
    vecs[3] = '{1'b0, 7'h7F, 8'h00, 8'hFF, 8'h00};
    vecs[4] = '{1'b1, 7'h00, 8'h00, 8'h00, 8'h1E};
    fvecs[0] = '{1'b1, 7'h21, 8'h01, 8'h00, 8'h1F};
    fvecs[1] = '{1'b0, 7'h22, 8'h02, 8'h5A, 8'h00};
    fvecs[2] = '{1'b1, 7'h23, 8'h03, 8'h00, 8'h1D};
    fvecs[3] = '{1'b1, 7'h24, 8'h04, 8'h00, 8'h1A};
    fvecs[4] = '{1'b0, 7'h25, 8'h05, 8'hC3, 8'h00};
    svecs[0] = '{1'b1, 7'h31, 8'h40, 8'h00, 8'h5E};
    svecs[1] = '{1'b1, 7'h32, 8'h41, 8'h00, 8'h5F};
    tvec     = '{1'b1, 7'h11, 8'h33, 8'h00, 8'h00};
    pvec     = '{1'b0, 7'h2B, 8'h77, 8'h3C, 8'h00};
    rvec     = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C};
    rst_exp  = {1'b1, 40'd0};

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rw = 1'b0;
    bus_if.cmd_slave_addr = 7'h00;
    bus_if.cmd_reg_addr = 8'h00;
    bus_if.cmd_wdata = 8'h00;
    bus_if.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs (rst high)", 64'(snap()), 64'(rst_exp));
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs (after release)", 64'(snap()), 64'(rst_exp));

    // Table-driven single commands
    for (int i = 0; i < 5; i++) begin
      push(vecs[i]);
      start_latency($sformatf("vec%0d", i));
      get_rsp($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Fill the FIFO with five commands while responses are consumed freely
    ready_hold = 1'b1;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(fvecs[i]);
    check("fifo level after 5 pushes", 64'(fifo_level), 64'd4);
    for (int i = 0; i < 5; i++) get_rsp($sformatf("fifo%0d", i), fvecs[i], 1'b0);
    ready_hold = 1'b0;
    bus_if.rsp_ready = 1'b0;
    check("fifo peak level", 64'(max_level), 64'd4);
    check("cmd_ready tracks !full", 64'(ready_err), 64'd0);

    // Response stall: two queued, rsp_ready low for 50 cycles
    push(svecs[0]);
    push(svecs[1]);
    k = 0;
    while (!bus_if.rsp_valid && k < 3000) begin @(negedge clk); k++; end
    held = {bus_if.rsp_valid, bus_if.rsp_rw, bus_if.rsp_rdata};
    e0 = en_cnt;
    stall_err = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({bus_if.rsp_valid, bus_if.rsp_rw, bus_if.rsp_rdata} !== held) stall_err++;
    end
    check("stall rsp fields stable", 64'(stall_err), 64'd0);
    check("stall no new en_start", 64'(en_cnt), 64'(e0));
    check("stall second cmd queued", 64'(fifo_level), 64'd1);
    get_rsp("stall0", svecs[0], 1'b0);
    get_rsp("stall1", svecs[1], 1'b0);

    // Timeout: no master activity, scl stays high
    master_on = 1'b0;
    push(tvec);
    k = 0;
    while (!m_en_start && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!bus_if.rsp_valid && k < 3000) begin @(negedge clk); k++; end
    check("timeout latency in range", 64'((k >= TO) && (k <= TO + 2)), 64'd1);
    get_rsp("timeout", tvec, 1'b1);
    @(negedge clk);
    check("timeout back to idle busy", 64'(busy), 64'd0);
    master_on = 1'b1;

    // Reset in the middle of a transaction
    push(pvec);
    k = 0;
    while (m_scl && k < 20) begin @(negedge clk); k++; end
    repeat (20) @(negedge clk);
    check("in flight before reset", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid-txn reset outputs", 64'(snap()), 64'(rst_exp));
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (in_txn && k < 500) begin @(negedge clk); k++; end
    check("master idle after reset", 64'(in_txn), 64'd0);
    @(negedge clk);
    push(rvec);
    start_latency("post-reset");
    get_rsp("post-reset", rvec, 1'b0);

    repeat (3) @(negedge clk);
    check("en_start never overlaps a transaction", 64'(en_overlap), 64'd0);
    check("total en_start pulses", 64'(en_cnt), 64'd15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
